// File: rtl/fp_flag_accum_if.sv
// Signal bundle between the FPU writeback stage and the FP flag/rounding-mode CSR block.
interface fp_flag_accum_if;
  logic [4:0] FlgM;
  logic       FlgValidM;
  logic       StallW;
  logic       FlushW;
  logic       CSRWriteW;
  logic [1:0] CSROpW;
  logic [1:0] CSRSelW;
  logic [7:0] CSRWDataW;
  logic [4:0] FFlags;
  logic [2:0] FRM;
  logic [7:0] FCSRReadW;
  logic       FSDirty;

  modport slave (
    input  FlgM, FlgValidM, StallW, FlushW, CSRWriteW, CSROpW, CSRSelW, CSRWDataW,
    output FFlags, FRM, FCSRReadW, FSDirty
  );

  modport master (
    output FlgM, FlgValidM, StallW, FlushW, CSRWriteW, CSROpW, CSRSelW, CSRWDataW,
    input  FFlags, FRM, FCSRReadW, FSDirty
  );
endinterface

// File: rtl/fp_flag_accum.sv
// Accrued FP exception flags (fflags) and rounding mode (frm) with CSR write/set/clear access.
// Define FP_FLAG_CNT_EN to add saturating per-flag event counters readable through CntIdx/CntVal.
module fp_flag_accum #(
  parameter int unsigned CNTW = 16
) (
  input logic          clk,
  input logic          reset_n,
  fp_flag_accum_if.slave bus
`ifdef FP_FLAG_CNT_EN
  ,
  input  logic [2:0]      CntIdx,
  output logic [CNTW-1:0] CntVal
`endif
);

  typedef enum logic [1:0] {
    OpWrite = 2'b00,
    OpSet   = 2'b01,
    OpClear = 2'b10,
    OpRsvd  = 2'b11
  } csrOpE;

  if (CNTW < 1) begin : gBadCntw
    $error("fp_flag_accum: CNTW must be at least 1");
  end

  logic [4:0] flgW_q, flgW_d;
  logic       flgValidW_q, flgValidW_d;
  logic [4:0] fFlags_q, fFlags_d;
  logic [2:0] frm_q, frm_d;
  logic       fsDirty_q, fsDirty_d;

  logic       retire;
  logic       csrUpdate;
  logic [4:0] retiredFlags;
  logic [2:0] frmSrc;
  csrOpE      csrOp;

  always_comb begin
    flgW_d      = flgW_q;
    flgValidW_d = flgValidW_q;
    if (!bus.StallW) begin
      flgW_d      = bus.FlgM;
      flgValidW_d = bus.FlgValidM & ~bus.FlushW;
    end
  end

  // Retiring flags are merged first so a same-cycle CSR op sees the post-retire value.
  always_comb begin
    retire       = flgValidW_q & ~bus.StallW & ~bus.FlushW;
    csrOp        = csrOpE'(bus.CSROpW);
    csrUpdate    = bus.CSRWriteW & ~bus.StallW & ~bus.FlushW &
                   (csrOp != OpRsvd) & (bus.CSRSelW != 2'b00);
    retiredFlags = retire ? (fFlags_q | flgW_q) : fFlags_q;
    frmSrc       = (bus.CSRSelW == 2'b11) ? bus.CSRWDataW[7:5] : bus.CSRWDataW[2:0];
    fFlags_d     = retiredFlags;
    frm_d        = frm_q;

    if (csrUpdate && bus.CSRSelW[0]) begin
      case (csrOp)
        OpWrite: fFlags_d = bus.CSRWDataW[4:0];
        OpSet:   fFlags_d = retiredFlags | bus.CSRWDataW[4:0];
        OpClear: fFlags_d = retiredFlags & ~bus.CSRWDataW[4:0];
        default: fFlags_d = retiredFlags;
      endcase
    end

    if (csrUpdate && bus.CSRSelW[1]) begin
      case (csrOp)
        OpWrite: frm_d = frmSrc;
        OpSet:   frm_d = frm_q | frmSrc;
        OpClear: frm_d = frm_q & ~frmSrc;
        default: frm_d = frm_q;
      endcase
    end

    fsDirty_d = ({frm_d, fFlags_d} != {frm_q, fFlags_q});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flgW_q      <= '0;
      flgValidW_q <= 1'b0;
      fFlags_q    <= '0;
      frm_q       <= '0;
      fsDirty_q   <= 1'b0;
    end else begin
      flgW_q      <= flgW_d;
      flgValidW_q <= flgValidW_d;
      fFlags_q    <= fFlags_d;
      frm_q       <= frm_d;
      fsDirty_q   <= fsDirty_d;
    end
  end

  assign bus.FFlags    = fFlags_q;
  assign bus.FRM       = frm_q;
  assign bus.FCSRReadW = {frm_q, fFlags_q};
  assign bus.FSDirty   = fsDirty_q;

`ifdef FP_FLAG_CNT_EN
  // Counter i follows flag bit i (0 = NX ... 4 = NV) and only FP retires touch it.
  logic [CNTW-1:0] cnt_q [5];
  logic [CNTW-1:0] cnt_d [5];

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = cnt_q[i];
      if (retire && flgW_q[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    CntVal = '0;
    if (CntIdx <= 3'd4) begin
      CntVal = cnt_q[CntIdx];
    end
  end
`endif

endmodule

// File: tb/tb_fp_flag_accum.sv
// Self-checking bench for fp_flag_accum: directed scenarios plus randomized traffic against a flag/CSR model.
module tb_fp_flag_accum;

  logic clk = 1'b0;
  logic reset_n;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk = ~clk;

  fp_flag_accum_if bus ();

`ifdef FP_FLAG_CNT_EN
  logic [2:0] cntIdx;
  logic [1:0] cntVal;
  fp_flag_accum #(.CNTW(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .CntIdx(cntIdx), .CntVal(cntVal)
  );
`else
  fp_flag_accum dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );
`endif

  // Reference model: architectural flags/frm, the pending writeback-stage entry, and event counts.
  logic [4:0] mFlags;
  logic [2:0] mFrm;
  logic [4:0] mPendF;
  logic       mPendV;
  logic       mDirty;
  int         mCnt [5];

  task automatic modelReset();
    mFlags = '0; mFrm = '0; mPendF = '0; mPendV = 1'b0; mDirty = 1'b0;
    for (int i = 0; i < 5; i++) mCnt[i] = 0;
  endtask

  task automatic applyStimulus(input logic [4:0] flg, input logic vld, input logic stall,
                               input logic flush, input logic csrW, input logic [1:0] op,
                               input logic [1:0] sel, input logic [7:0] data);
    bus.FlgM = flg; bus.FlgValidM = vld; bus.StallW = stall; bus.FlushW = flush;
    bus.CSRWriteW = csrW; bus.CSROpW = op; bus.CSRSelW = sel; bus.CSRWDataW = data;
  endtask

  // Advance one clock: update the model from the inputs held across the edge, then sample #1 later.
  task automatic cycle();
    logic       ret;
    logic       csrGo;
    logic [4:0] nf;
    logic [2:0] nr;
    logic [4:0] sf;
    logic [2:0] sr;
    ret   = mPendV && !bus.StallW && !bus.FlushW;
    csrGo = bus.CSRWriteW && !bus.StallW && !bus.FlushW && bus.CSROpW != 2'd3 && bus.CSRSelW != 2'd0;
    nf    = ret ? (mFlags | mPendF) : mFlags;
    nr    = mFrm;
    sf    = bus.CSRWDataW[4:0];
    sr    = (bus.CSRSelW == 2'd2) ? bus.CSRWDataW[2:0] : bus.CSRWDataW[7:5];
    if (csrGo && (bus.CSRSelW == 2'd1 || bus.CSRSelW == 2'd3)) begin
      if (bus.CSROpW == 2'd0) nf = sf;
      else if (bus.CSROpW == 2'd1) nf = nf | sf;
      else nf = nf & ~sf;
    end
    if (csrGo && (bus.CSRSelW == 2'd2 || bus.CSRSelW == 2'd3)) begin
      if (bus.CSROpW == 2'd0) nr = sr;
      else if (bus.CSROpW == 2'd1) nr = nr | sr;
      else nr = nr & ~sr;
    end
    mDirty = ({nr, nf} != {mFrm, mFlags});
    if (ret) begin
      for (int i = 0; i < 5; i++) if (mPendF[i] && mCnt[i] < 3) mCnt[i]++;
    end
    if (!bus.StallW) begin
      mPendF = bus.FlgM;
      mPendV = bus.FlushW ? 1'b0 : bus.FlgValidM;
    end
    mFlags = nf;
    mFrm   = nr;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    reset_n = 1'b0;
    #3;
    modelReset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    reset_n = 1'b0;
    #3;
    checkCount++;
    if (bus.FCSRReadW !== 8'h00) $display("[TB] FAIL reset_fcsr: got %h want 00", bus.FCSRReadW); else passCount++;
    checkCount++;
    if (bus.FSDirty !== 1'b0) $display("[TB] FAIL reset_dirty: got %b want 0", bus.FSDirty); else passCount++;
    modelReset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_retire_latency();
    doReset();
    applyStimulus(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    cycle();
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    checkCount++;
    if (bus.FFlags !== 5'b00000) $display("[TB] FAIL latency_edge1: got %b want 00000", bus.FFlags); else passCount++;
    cycle();
    checkCount++;
    if (bus.FFlags !== 5'b00001) $display("[TB] FAIL latency_edge2: got %b want 00001", bus.FFlags); else passCount++;
    checkCount++;
    if (bus.FSDirty !== 1'b1) $display("[TB] FAIL latency_dirty_on: got %b want 1", bus.FSDirty); else passCount++;
    cycle();
    checkCount++;
    if (bus.FSDirty !== 1'b0) $display("[TB] FAIL latency_dirty_off: got %b want 0", bus.FSDirty); else passCount++;
  endtask

  task automatic test_csr_same_cycle();
    doReset();
    applyStimulus(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    cycle();
    applyStimulus(5'b10000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    cycle();
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 8'h01);
    cycle();
    checkCount++;
    if (bus.FFlags !== 5'b10000) $display("[TB] FAIL retire_then_clear: got %b want 10000", bus.FFlags); else passCount++;
    checkCount++;
    if (bus.FRM !== 3'b000) $display("[TB] FAIL fflags_op_frm: got %b want 000", bus.FRM); else passCount++;
  endtask

  task automatic test_flush();
    doReset();
    applyStimulus(5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    cycle();
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0);
    cycle();
    checkCount++;
    if (bus.FFlags !== 5'b00000 || bus.FSDirty !== 1'b0)
      $display("[TB] FAIL flush_squash: got %b/%b want 00000/0", bus.FFlags, bus.FSDirty); else passCount++;
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    cycle();
    checkCount++;
    if (bus.FFlags !== 5'b00000) $display("[TB] FAIL flush_late: got %b want 00000", bus.FFlags); else passCount++;
`ifdef FP_FLAG_CNT_EN
    cntIdx = 3'd3;
    #1;
    checkCount++;
    if (cntVal !== 2'd0) $display("[TB] FAIL flush_counter: got %0d want 0", cntVal); else passCount++;
`endif
  endtask

  task automatic test_stall();
    doReset();
    applyStimulus(5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    cycle();
    applyStimulus(5'b11111, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkCount++;
      if (bus.FFlags !== 5'b00000) $display("[TB] FAIL stall_hold%0d: got %b want 00000", i, bus.FFlags); else passCount++;
    end
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    cycle();
    checkCount++;
    if (bus.FFlags !== 5'b00100 || bus.FSDirty !== 1'b1)
      $display("[TB] FAIL stall_release: got %b/%b want 00100/1", bus.FFlags, bus.FSDirty); else passCount++;
    cycle();
    checkCount++;
    if (bus.FFlags !== 5'b00100 || bus.FSDirty !== 1'b0)
      $display("[TB] FAIL stall_once: got %b/%b want 00100/0", bus.FFlags, bus.FSDirty); else passCount++;
  endtask

  task automatic test_fcsr_write();
    doReset();
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 8'hE3);
    cycle();
    checkCount++;
    if (bus.FRM !== 3'b111 || bus.FFlags !== 5'b00011 || bus.FCSRReadW !== 8'hE3 || bus.FSDirty !== 1'b1)
      $display("[TB] FAIL fcsr_write: got frm=%b flags=%b rd=%h dirty=%b want 111/00011/e3/1",
               bus.FRM, bus.FFlags, bus.FCSRReadW, bus.FSDirty);
    else passCount++;
    cycle();
    checkCount++;
    if (bus.FCSRReadW !== 8'hE3 || bus.FSDirty !== 1'b0)
      $display("[TB] FAIL fcsr_repeat: got rd=%h dirty=%b want e3/0", bus.FCSRReadW, bus.FSDirty); else passCount++;
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 8'h05);
    cycle();
    checkCount++;
    if (bus.FCSRReadW !== 8'h43) $display("[TB] FAIL frm_clear: got %h want 43", bus.FCSRReadW); else passCount++;
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    applyStimulus(5'b10000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    cycle();
    applyStimulus(5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    cycle();
    doReset();
    applyStimulus(5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    cycle();
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    cycle();
    checkCount++;
    if (bus.FFlags !== 5'b00010) $display("[TB] FAIL reset_mid_stall: got %b want 00010", bus.FFlags); else passCount++;
  endtask

`ifdef FP_FLAG_CNT_EN
  task automatic test_counters();
    doReset();
    cntIdx = 3'd0;
    applyStimulus(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    for (int i = 0; i < 4; i++) cycle();
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 8'h1F);
    cycle();
    checkCount++;
    if (cntVal !== 2'b11) $display("[TB] FAIL cnt_saturate: got %b want 11", cntVal); else passCount++;
    cntIdx = 3'd6;
    #1;
    checkCount++;
    if (cntVal !== 2'b00) $display("[TB] FAIL cnt_bad_idx: got %b want 00", cntVal); else passCount++;
    cntIdx = 3'd0;
    reset_n = 1'b0;
    #2;
    checkCount++;
    if (cntVal !== 2'b00) $display("[TB] FAIL cnt_reset: got %b want 00", cntVal); else passCount++;
    modelReset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask
`endif

  task automatic test_random();
    int errs;
    errs = 0;
    doReset();
    for (int n = 0; n < 400; n++) begin
      applyStimulus(5'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0), 2'($urandom), 2'($urandom), 8'($urandom));
`ifdef FP_FLAG_CNT_EN
      cntIdx = 3'($urandom);
`endif
      cycle();
      checkCount++;
      if ({bus.FSDirty, bus.FCSRReadW, bus.FRM, bus.FFlags} !== {mDirty, mFrm, mFlags, mFrm, mFlags}) begin
        if (errs < 5)
          $display("[TB] FAIL random_state@%0d: got dirty=%b rd=%h want dirty=%b rd=%h",
                   n, bus.FSDirty, bus.FCSRReadW, mDirty, {mFrm, mFlags});
        errs++;
      end else passCount++;
`ifdef FP_FLAG_CNT_EN
      checkCount++;
      if (cntVal !== ((cntIdx <= 3'd4) ? 2'(mCnt[cntIdx]) : 2'd0)) begin
        if (errs < 5) $display("[TB] FAIL random_cnt@%0d: got %0d idx %0d", n, cntVal, cntIdx);
        errs++;
      end else passCount++;
`endif
    end
  endtask

  initial begin
    reset_n = 1'b0;
`ifdef FP_FLAG_CNT_EN
    cntIdx = 3'd0;
`endif
    modelReset();
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    @(posedge clk);
    #1;
    test_reset();
    test_retire_latency();
    test_csr_same_cycle();
    test_flush();
    test_stall();
    test_fcsr_write();
    test_reset_mid_stall();
`ifdef FP_FLAG_CNT_EN
    test_counters();
`endif
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fp_flag_accum.md
FP_FLAG_ACCUM -- requirements
Module: fp_flag_accum

Interface
REQ-001 Parameter CNTW, default 16: width of each per-flag event counter (used only when FP_FLAG_CNT_EN is defined).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 FlgM  input  5  post-processing flags {NV,DZ,OF,UF,NX} from the FPU memory stage.
REQ-005 FlgValidM  input  1  FlgM belongs to an FP instruction that writes fflags.
REQ-006 StallW  input  1  writeback stage stalled.
REQ-007 FlushW  input  1  writeback-stage instruction squashed.
REQ-008 CSRWriteW  input  1  CSR instruction in writeback updates the FP CSRs.
REQ-009 CSROpW  input  2  00 write, 01 set, 10 clear, 11 reserved (no update).
REQ-010 CSRSelW  input  2  01 fflags, 10 frm, 11 fcsr, 00 none.
REQ-011 CSRWDataW  input  8  CSR source operand, right-aligned to the selected field.
REQ-012 FFlags  output  5  architectural accrued flags.
REQ-013 FRM  output  3  architectural dynamic rounding mode.
REQ-014 FCSRReadW  output  8  {FRM,FFlags} combinational read value before this cycle's update.
REQ-015 FSDirty  output  1  one-cycle pulse when FFlags or FRM changes value.
REQ-016 CntIdx  input  3  counter select 0-4 (NV..NX order 4..0); present only with FP_FLAG_CNT_EN.
REQ-017 CntVal  output  CNTW  selected counter value; present only with FP_FLAG_CNT_EN.

Function
REQ-018 Pipeline register FlgW/FlgValidW SHALL capture FlgM/FlgValidM when ~StallW; it SHALL hold when StallW; FlgValidW SHALL clear when FlushW & ~StallW.
REQ-019 Retire SHALL occur when FlgValidW & ~StallW & ~FlushW; latency from FlgM to FFlags is 2 rising edges with no stalls.
REQ-020 On retire, FFlags SHALL become FFlags | FlgW (sticky OR; bits never cleared by FP ops).
REQ-021 CSR update SHALL occur when CSRWriteW & ~StallW & ~FlushW & CSROpW!=11 & CSRSelW!=00.
REQ-022 CSR write/set/clear SHALL compute new = src, old|src, old&~src on the selected field(s); fcsr uses CSRWDataW[7:5] for FRM, [4:0] for FFlags.
REQ-023 Retire and CSR update in the same cycle: CSR operation SHALL be applied to (FFlags | FlgW), i.e. retire first, then CSR.
REQ-024 CSR op on frm only SHALL not affect FFlags beyond REQ-020; on fflags only SHALL not affect FRM.
REQ-025 FCSRReadW SHALL reflect registered FFlags/FRM and SHALL not include same-cycle retiring flags.
REQ-026 FSDirty SHALL assert in the cycle after any edge where {FRM,FFlags} changed, for exactly one cycle per change.
REQ-027 Stall held for N cycles with FlgValidW set SHALL retire exactly once after StallW deasserts.

Reset
REQ-028 On reset_n low, asynchronously: FFlags=0, FRM=0, FlgW=0, FlgValidW=0, FSDirty=0, all counters=0.
REQ-029 Reset asserted mid-stall SHALL discard pending FlgW; first retire after release SHALL only come from newly captured FlgM.

Configuration
REQ-030 Macro FP_FLAG_CNT_EN: when defined, five CNTW-bit counters SHALL each increment by 1 on every retire whose FlgW bit is set, saturating at all-ones, unaffected by CSR ops; CntVal SHALL show counter CntIdx (0 for CntIdx>4).
REQ-031 Without FP_FLAG_CNT_EN: no counters, CntIdx/CntVal ports absent, all other behaviour identical.

Verification
REQ-032 Reset, FlgM=5'b00001 FlgValidM=1 one cycle -> FFlags=5'b00001 after 2 edges, FSDirty pulses once.
REQ-033 FFlags=5'b00001, retire FlgW=5'b10000 with same-cycle CSR clear fflags src=5'b00001 -> FFlags=5'b10000.
REQ-034 FlgValidW=1 FlgW=5'b01000 with FlushW=1 -> FFlags unchanged, no FSDirty, no counter increment.
REQ-035 StallW held 3 cycles with FlgValidW=1 FlgW=5'b00100 -> FFlags updates once, on the edge after StallW drops.
REQ-036 CSR write fcsr 8'hE3 -> FRM=3'b111, FFlags=5'b00011, FCSRReadW=8'hE3 next cycle; a repeat write leaves FSDirty low.
REQ-037 FP_FLAG_CNT_EN with CNTW=2: four NX retires -> CntVal(CntIdx=0)=2'b11 (saturated); reset_n low -> 0.
